mips_avalon_mem_responder: RTL and testbench

Memory-side responder for the CPU's Avalon-MM style data/instruction port, the target that answers the decoder-driven MemRead/MemWrite/ByteEn requests.
- Holds a word-addressed RAM window at BASE_ADDR.
- Stalls each request with a programmable number of waitrequest cycles.
- Applies byte-enabled writes.
- Flags protocol and address errors.
- Used as the bench memory behind the CPU and as on-chip scratch RAM.

---
 rtl/mips_avalon_mem_responder.sv | 100 ++++++++++
 tb/tb_mips_avalon_mem_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mips_avalon_mem_responder.sv
// mips_avalon_mem_responder: Avalon-MM RAM window with programmable waitrequest stall, byte-enabled writes, sticky error flag.
// Optional feature macro: MEM_RAND_WAIT_EN (LFSR-randomised stall of 1..4 cycles instead of WAIT_CYCLES).
// Ports: clk, reset (async, active-high); address/read/write/byteenable/writedata request inputs;
//        waitrequest (high = not yet accepted), readdata (valid in completion cycle only), err (sticky until reset).
module mips_avalon_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        err
);
    localparam logic [0:0]  IDLE = 1'b0;
    localparam logic [0:0]  BUSY = 1'b1;
    localparam logic [32:0] SPAN = 33'd4 << ADDR_WIDTH;

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 1..15");
    end

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d, wait_n;
    logic                  err_q, err_d;
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [32:0]           off;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  req, in_range, aligned, fin, ok;

    assign req      = read | write;
    // 33-bit offset: bit 32 set means address lies below BASE_ADDR
    assign off      = {1'b0, address} - {1'b0, BASE_ADDR};
    assign in_range = !off[32] && off < SPAN;
    assign idx      = off[ADDR_WIDTH+1:2];
    assign aligned  = address[1:0] == 2'b00;
    // completion cycle; only a real transfer if the request is still held
    assign fin      = state_q == BUSY && cnt_q == 4'd0;
    assign ok       = fin && req && in_range && aligned && !(read && write);

    assign waitrequest = req && !fin;
    assign readdata    = ok && read ? mem[idx] : 32'h0;
    assign err         = err_q;

`ifdef MEM_RAND_WAIT_EN
    logic [7:0] lfsr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    assign wait_n = 4'd1 + {2'b00, lfsr_q[1:0]};
`else
    assign wait_n = 4'(WAIT_CYCLES);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (state_q == IDLE) begin
            if (req) begin
                state_d = BUSY;
                cnt_d   = wait_n - 4'd1;
            end
        end else if (!req) begin
            // request withdrawn before completion: protocol violation
            state_d = IDLE;
            err_d   = 1'b1;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            state_d = IDLE;
            err_d   = err_q | !ok;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ok && write)
            for (int i = 0; i < 4; i++)
                if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
    end
endmodule

// File: tb/tb_mips_avalon_mem_responder.sv
// tb_mips_avalon_mem_responder: directed self-checking bench for mips_avalon_mem_responder (WAIT_CYCLES=3).
module tb_mips_avalon_mem_responder;
    logic        clk = 1'b0, reset = 1'b1, read = 1'b0, write = 1'b0;
    logic [31:0] address = 32'h0, writedata = 32'h0;
    logic [3:0]  byteenable = 4'h0;
    logic        waitrequest, err;
    logic [31:0] readdata, rd;
    logic [7:0]  lfsr_m;
    int          passed = 0, total = 0, n;

    mips_avalon_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'hBFC00000), .WAIT_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata), .err(err)
    );

    always #5 clk = ~clk;

    // reference LFSR x^8+x^6+x^5+x^4+1 seeded 8'hA5
    always @(posedge clk or posedge reset) begin
        if (reset) lfsr_m <= 8'hA5;
        else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    function automatic int exp_wait();
`ifdef MEM_RAND_WAIT_EN
        return 1 + int'(lfsr_m[1:0]);
`else
        return 3;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic xfer(input string tag, input logic r, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, output logic [31:0] data, output int cnt);
        int   ew;
        logic z;
        cnt = 0;
        z   = 1'b1;
        @(negedge clk);
        read = r; write = wr; address = a; byteenable = be; writedata = wd;
        #1;
        ew = exp_wait();
        while (waitrequest === 1'b1 && cnt < 40) begin
            if (readdata !== 32'h0) z = 1'b0;
            cnt++;
            @(negedge clk);
            #1;
        end
        data = readdata;
        chk({tag, " waits"}, cnt, ew);
        chk({tag, " rdata zero while waiting"}, z, 1);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        #1;
        chk("reset err", err, 0);
        chk("reset waitrequest idle", waitrequest, 0);
        chk("reset readdata", readdata, 0);
        write = 1'b1;
        #1;
        chk("reset waitrequest follows req", waitrequest, 1);
        write = 1'b0;
        #20;
        @(negedge clk) reset = 1'b0;

        // full-word write then read
        xfer("wr0", 0, 1, 32'hBFC00000, 4'hF, 32'h12345678, rd, n);
        xfer("rd0", 1, 0, 32'hBFC00000, 4'h0, 32'h0, rd, n);
        chk("rd0 data", rd, 32'h12345678);

        // reset in the middle of a write must discard it
        xfer("pre4", 0, 1, 32'hBFC00010, 4'hF, 32'h44444444, rd, n);
        @(negedge clk);
        write = 1'b1; address = 32'hBFC00010; writedata = 32'hDEADBEEF; byteenable = 4'hF;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid reset err", err, 0);
        chk("mid reset waitrequest follows req", waitrequest, 1);
        write = 1'b0;
        #1;
        chk("mid reset waitrequest low", waitrequest, 0);
        @(negedge clk) reset = 1'b0;
        xfer("rd4", 1, 0, 32'hBFC00010, 4'h0, 32'h0, rd, n);
        chk("word4 unchanged", rd, 32'h44444444);

        // byte lanes
        xfer("wr1 full", 0, 1, 32'hBFC00004, 4'hF, 32'hAABBCCDD, rd, n);
        xfer("wr1 lanes", 0, 1, 32'hBFC00004, 4'b0101, 32'h11223344, rd, n);
        xfer("rd1", 1, 0, 32'hBFC00004, 4'h0, 32'h0, rd, n);
        chk("byte lanes merge", rd, 32'hAA22CC44);
        xfer("wr1 be0", 0, 1, 32'hBFC00004, 4'h0, 32'hFFFFFFFF, rd, n);
        xfer("rd1 again", 1, 0, 32'hBFC00004, 4'h0, 32'h0, rd, n);
        chk("byteenable 0 no-op", rd, 32'hAA22CC44);
        chk("err clear after legal traffic", err, 0);

        // range boundaries
        xfer("wr last", 0, 1, 32'hBFC00FFC, 4'hF, 32'hCAFEF00D, rd, n);
        xfer("rd last", 1, 0, 32'hBFC00FFC, 4'h0, 32'h0, rd, n);
        chk("last word data", rd, 32'hCAFEF00D);
        chk("last word no err", err, 0);
        xfer("rd past end", 1, 0, 32'hBFC01000, 4'h0, 32'h0, rd, n);
        chk("past end rdata", rd, 0);
        chk("past end err", err, 1);
        xfer("wr past end", 0, 1, 32'hBFC01000, 4'hF, 32'hFFFFFFFF, rd, n);
        xfer("rd word0", 1, 0, 32'hBFC00000, 4'h0, 32'h0, rd, n);
        chk("past end write ignored", rd, 32'h12345678);
        xfer("rd misaligned", 1, 0, 32'hBFC00002, 4'h0, 32'h0, rd, n);
        chk("misaligned rdata", rd, 0);
        chk("err stays set", err, 1);

        pulse_reset();
        chk("err cleared by reset", err, 0);
        xfer("wr misaligned", 0, 1, 32'hBFC00006, 4'hF, 32'hFFFFFFFF, rd, n);
        chk("misaligned sets err", err, 1);
        xfer("rd1 after misaligned", 1, 0, 32'hBFC00004, 4'h0, 32'h0, rd, n);
        chk("misaligned write ignored", rd, 32'hAA22CC44);

        pulse_reset();
        xfer("rd below base", 1, 0, 32'hBFBFFFFC, 4'h0, 32'h0, rd, n);
        chk("below base rdata", rd, 0);
        chk("below base err", err, 1);

        // read and write together
        xfer("wr2", 0, 1, 32'hBFC00008, 4'hF, 32'h22222222, rd, n);
        pulse_reset();
        xfer("rw2", 1, 1, 32'hBFC00008, 4'hF, 32'h99999999, rd, n);
        chk("read+write rdata", rd, 0);
        chk("read+write err", err, 1);
        xfer("rd2", 1, 0, 32'hBFC00008, 4'h0, 32'h0, rd, n);
        chk("read+write no RAM change", rd, 32'h22222222);

`ifndef MEM_RAND_WAIT_EN
        // request withdrawn after one wait cycle
        pulse_reset();
        @(negedge clk);
        write = 1'b1; address = 32'hBFC00008; writedata = 32'h99999999; byteenable = 4'hF;
        #1 chk("drop idle wait", waitrequest, 1);
        @(negedge clk);
        #1 chk("drop busy wait", waitrequest, 1);
        write = 1'b0;
        #1 chk("drop waitrequest low", waitrequest, 0);
        @(negedge clk);
        #1 chk("drop err", err, 1);
        xfer("rd2 after drop", 1, 0, 32'hBFC00008, 4'h0, 32'h0, rd, n);
        chk("drop no write", rd, 32'h22222222);
`else
        pulse_reset();
        for (int i = 0; i < 50; i++) begin
            xfer("rand rd", 1, 0, 32'hBFC00000, 4'h0, 32'h0, rd, n);
            chk("rand run in 1..4", (n >= 1 && n <= 4) ? 1 : 0, 1);
            chk("rand rd data", rd, 32'h12345678);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
